// File: rtl/sram_d_obi_mux.sv
// Round-robin merge of two OBI masters onto the SRAM data port.
// Out-of-window requests are answered locally with an error word.
module sram_d_obi_mux #(
   parameter logic [31:0] SRAM_BASE_ADDR  = 32'h8000_0000,
   parameter logic [31:0] SRAM_END_ADDR   = 32'h8000_C000,
   parameter int unsigned NUM_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        sram_d_req_o,
   input  logic        sram_d_gnt_i,
   output logic [31:0] sram_d_addr_o,
   output logic        sram_d_we_o,
   output logic [3:0]  sram_d_be_o,
   output logic [31:0] sram_d_wdata_o,
   input  logic        sram_d_rvalid_i,
   input  logic [31:0] sram_d_rdata_i,
   output logic        illegal_access_o
);

   localparam int PW = $clog2(NUM_OUTSTANDING) + 1;
   localparam int AD = 1 << PW;
   localparam logic [PW-1:0] DEPTH = PW'(NUM_OUTSTANDING);
   localparam logic [PW-1:0] LAST  = PW'(NUM_OUTSTANDING - 1);
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   logic          fifo_id_q  [AD];
   logic          fifo_err_q [AD];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic          lock_q, lock_d;
   logic          lock_id_q, lock_id_d;
   logic          prio_q, prio_d;

   logic          full, empty;
   logic          elig0, elig1;
   logic          win_valid, win_id;
   logic [31:0]   win_addr, win_wdata;
   logic          win_we;
   logic [3:0]    win_be;
   logic          illegal, fwd, accept;
   logic          head_id, head_err, pop;
   logic [31:0]   rsp_data;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign full  = (cnt_q == DEPTH);
   assign empty = (cnt_q == '0);
   assign elig0 = rst_ni & m0_req_i & ~full;
   assign elig1 = rst_ni & m1_req_i & ~full;

   // Pick the winner: a stalled request keeps its master, else round-robin.
   always_comb begin
      win_valid = 1'b0;
      win_id    = 1'b0;
      priority case (1'b1)
         lock_q: begin
            win_id    = lock_id_q;
            win_valid = lock_id_q ? elig1 : elig0;
         end
         elig0 && elig1: begin
            win_valid = 1'b1;
            win_id    = prio_q;
         end
         elig0: win_valid = 1'b1;
         elig1: begin
            win_valid = 1'b1;
            win_id    = 1'b1;
         end
         default: ;
      endcase
   end

   assign win_addr  = win_id ? m1_addr_i  : m0_addr_i;
   assign win_we    = win_id ? m1_we_i    : m0_we_i;
   assign win_be    = win_id ? m1_be_i    : m0_be_i;
   assign win_wdata = win_id ? m1_wdata_i : m0_wdata_i;

   assign illegal = (win_addr < SRAM_BASE_ADDR) ||
                    (win_addr >= SRAM_END_ADDR);
   assign fwd     = win_valid & ~illegal;
   assign accept  = win_valid & (illegal | sram_d_gnt_i);

   assign sram_d_req_o     = fwd;
   assign sram_d_addr_o    = fwd ? win_addr  : '0;
   assign sram_d_we_o      = fwd ? win_we    : 1'b0;
   assign sram_d_be_o      = fwd ? win_be    : '0;
   assign sram_d_wdata_o   = fwd ? win_wdata : '0;
   assign illegal_access_o = win_valid & illegal;
   assign m0_gnt_o         = accept & ~win_id;
   assign m1_gnt_o         = accept & win_id;

   assign head_id  = fifo_id_q[rd_ptr_q];
   assign head_err = fifo_err_q[rd_ptr_q];
   assign pop      = ~empty & (head_err | sram_d_rvalid_i);
   assign rsp_data = head_err ? ERR_WORD : sram_d_rdata_i;

   assign m0_rvalid_o = pop & ~head_id;
   assign m1_rvalid_o = pop & head_id;
   assign m0_rdata_o  = pop ? rsp_data : '0;
   assign m1_rdata_o  = pop ? rsp_data : '0;

   // Next-state for FIFO pointers, occupancy, lock and priority.
   always_comb begin
      wr_ptr_d  = accept ? inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop ? inc(rd_ptr_q) : rd_ptr_q;
      cnt_d     = cnt_q;
      unique case ({accept, pop})
         2'b10:   cnt_d = cnt_q + PW'(1);
         2'b01:   cnt_d = cnt_q - PW'(1);
         default: cnt_d = cnt_q;
      endcase
      lock_d    = fwd & ~sram_d_gnt_i;
      lock_id_d = win_id;
      prio_d    = accept ? ~win_id : prio_q;
   end

   // State registers and in-order ID FIFO storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         prio_q    <= 1'b0;
         for (int i = 0; i < AD; i++) begin
            fifo_id_q[i]  <= 1'b0;
            fifo_err_q[i] <= 1'b0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         prio_q    <= prio_d;
         if (accept) begin
            fifo_id_q[wr_ptr_q]  <= win_id;
            fifo_err_q[wr_ptr_q] <= illegal;
         end
      end
   end

   // Flag a slave response that has no legal entry waiting for it.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(sram_d_rvalid_i && (empty || head_err)))
         else $warning("sram_d_rvalid_i without pending legal entry, dropped");
      end
   end

endmodule

// File: tb/tb_sram_d_obi_mux.sv
// Directed bench for sram_d_obi_mux.
// Two masters, hand-driven slave, immediate-assertion checks.
module tb_sram_d_obi_mux;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        m0_req = 0, m1_req = 0;
   logic        m0_gnt, m1_gnt;
   logic [31:0] m0_addr = 0, m1_addr = 0;
   logic        m0_we = 0, m1_we = 0;
   logic [3:0]  m0_be = 4'hF, m1_be = 4'h3;
   logic [31:0] m0_wdata = 32'h0000_00A0, m1_wdata = 32'h0000_00B1;
   logic        m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_req, s_we;
   logic        s_gnt = 0, s_rvalid = 0;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_be;
   logic [31:0] s_rdata = 0;
   logic        ill;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_d_obi_mux dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr),
      .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
      .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr),
      .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
      .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
      .sram_d_req_o(s_req), .sram_d_gnt_i(s_gnt),
      .sram_d_addr_o(s_addr), .sram_d_we_o(s_we),
      .sram_d_be_o(s_be), .sram_d_wdata_o(s_wdata),
      .sram_d_rvalid_i(s_rvalid), .sram_d_rdata_i(s_rdata),
      .illegal_access_o(ill)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic slv(input logic g, input logic rv, input logic [31:0] d);
      s_gnt = g;
      s_rvalid = rv;
      s_rdata = d;
   endtask

   initial begin
      // reset with a live request: everything must stay quiet
      m0_req = 1; m0_addr = 32'h8000_0000;
      slv(1, 1, 32'h1234_5678);
      #12;
      chk("rst_sreq", s_req, 0);
      chk("rst_gnt0", m0_gnt, 0);
      chk("rst_addr", s_addr, 0);
      chk("rst_rv0", m0_rvalid, 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_ill", ill, 0);
      nxt();
      rst_ni = 1;
      // alternating masters
      m1_req = 1; m1_addr = 32'h8000_BFFC;
      slv(1, 0, 0);
      settle();
      chk("alt1_addr", s_addr, 32'h8000_0000);
      chk("alt1_be", s_be, 4'hF);
      chk("alt1_g0", m0_gnt, 1);
      chk("alt1_g1", m1_gnt, 0);
      nxt();
      slv(1, 1, 32'h1111_1111);
      settle();
      chk("alt2_addr", s_addr, 32'h8000_BFFC);
      chk("alt2_g1", m1_gnt, 1);
      chk("alt2_g0", m0_gnt, 0);
      chk("alt2_rv0", m0_rvalid, 1);
      chk("alt2_rv1", m1_rvalid, 0);
      chk("alt2_rd0", m0_rdata, 32'h1111_1111);
      nxt();
      slv(1, 1, 32'h2222_2222);
      settle();
      chk("alt3_g0", m0_gnt, 1);
      chk("alt3_rv1", m1_rvalid, 1);
      chk("alt3_rv0", m0_rvalid, 0);
      chk("alt3_rd1", m1_rdata, 32'h2222_2222);
      nxt();
      m0_req = 0; m1_req = 0;
      slv(1, 1, 32'h3333_3333);
      settle();
      chk("alt4_rv0", m0_rvalid, 1);
      chk("alt4_rd0", m0_rdata, 32'h3333_3333);
      chk("idle_req", s_req, 0);
      chk("idle_addr", s_addr, 0);
      // lock under stall; priority now points at m1
      nxt();
      m0_req = 1; m0_addr = 32'h8000_0100;
      slv(0, 0, 0);
      settle();
      chk("lk1_addr", s_addr, 32'h8000_0100);
      chk("lk1_g0", m0_gnt, 0);
      nxt();
      m1_req = 1; m1_addr = 32'h8000_0200;
      settle();
      chk("lk2_addr", s_addr, 32'h8000_0100);
      chk("lk2_g1", m1_gnt, 0);
      nxt();
      settle();
      chk("lk3_addr", s_addr, 32'h8000_0100);
      chk("lk3_g1", m1_gnt, 0);
      nxt();
      slv(1, 0, 0);
      settle();
      chk("lk4_addr", s_addr, 32'h8000_0100);
      chk("lk4_g0", m0_gnt, 1);
      chk("lk4_g1", m1_gnt, 0);
      nxt();
      m0_req = 0;
      slv(1, 1, 32'h4444_4444);
      settle();
      chk("lk5_g1", m1_gnt, 1);
      chk("lk5_addr", s_addr, 32'h8000_0200);
      chk("lk5_rv0", m0_rvalid, 1);
      chk("lk5_rd0", m0_rdata, 32'h4444_4444);
      nxt();
      m1_req = 0;
      slv(1, 1, 32'h5555_5555);
      settle();
      chk("lk6_rv1", m1_rvalid, 1);
      chk("lk6_rd1", m1_rdata, 32'h5555_5555);
      // illegal access from m1
      nxt();
      m1_req = 1; m1_addr = 32'h0000_1000;
      slv(1, 0, 0);
      settle();
      chk("il1_g1", m1_gnt, 1);
      chk("il1_sreq", s_req, 0);
      chk("il1_ill", ill, 1);
      nxt();
      m1_req = 0;
      settle();
      chk("il2_rv1", m1_rvalid, 1);
      chk("il2_rv0", m0_rvalid, 0);
      chk("il2_rd1", m1_rdata, 32'hDEAD_BEEF);
      chk("il2_ill", ill, 0);
      // FIFO full with depth 2
      nxt();
      settle();
      chk("il3_rv1", m1_rvalid, 0);
      m0_req = 1; m0_addr = 32'h8000_1000;
      settle();
      chk("ff1_g0", m0_gnt, 1);
      nxt();
      m0_addr = 32'h8000_1004;
      settle();
      chk("ff2_g0", m0_gnt, 1);
      nxt();
      m0_addr = 32'h8000_1008;
      settle();
      chk("ff3_g0", m0_gnt, 0);
      chk("ff3_sreq", s_req, 0);
      nxt();
      slv(1, 1, 32'hAAAA_0001);
      settle();
      chk("ff4_g0", m0_gnt, 0);
      chk("ff4_rv0", m0_rvalid, 1);
      chk("ff4_rd0", m0_rdata, 32'hAAAA_0001);
      nxt();
      slv(1, 0, 0);
      settle();
      chk("ff5_g0", m0_gnt, 1);
      chk("ff5_addr", s_addr, 32'h8000_1008);
      nxt();
      m0_req = 0;
      slv(1, 1, 32'hAAAA_0002);
      settle();
      chk("ff6_rd0", m0_rdata, 32'hAAAA_0002);
      nxt();
      slv(1, 1, 32'hAAAA_0003);
      settle();
      chk("ff7_rv0", m0_rvalid, 1);
      chk("ff7_rd0", m0_rdata, 32'hAAAA_0003);
      // error entry behind a legal one; end address is exclusive
      nxt();
      m0_req = 1; m0_addr = 32'h8000_2000;
      slv(1, 0, 0);
      settle();
      chk("eq1_g0", m0_gnt, 1);
      nxt();
      m0_req = 0;
      m1_req = 1; m1_addr = 32'h8000_C000;
      settle();
      chk("eq2_g1", m1_gnt, 1);
      chk("eq2_ill", ill, 1);
      chk("eq2_rv1", m1_rvalid, 0);
      nxt();
      m1_req = 0;
      slv(1, 1, 32'h6666_6666);
      settle();
      chk("eq3_rv0", m0_rvalid, 1);
      chk("eq3_rv1", m1_rvalid, 0);
      chk("eq3_rd0", m0_rdata, 32'h6666_6666);
      nxt();
      slv(1, 0, 0);
      settle();
      chk("eq4_rv1", m1_rvalid, 1);
      chk("eq4_rd1", m1_rdata, 32'hDEAD_BEEF);
      // reset with two outstanding reads
      nxt();
      m0_req = 1; m0_addr = 32'h8000_3000;
      settle();
      chk("rm1_g0", m0_gnt, 1);
      nxt();
      m0_addr = 32'h8000_3004;
      settle();
      chk("rm2_g0", m0_gnt, 1);
      nxt();
      rst_ni = 0;
      slv(1, 1, 32'h7777_7777);
      settle();
      chk("rm3_sreq", s_req, 0);
      chk("rm3_g0", m0_gnt, 0);
      chk("rm3_rv0", m0_rvalid, 0);
      chk("rm3_rd0", m0_rdata, 0);
      chk("rm3_addr", s_addr, 0);
      nxt();
      rst_ni = 1;
      m0_req = 0;
      slv(1, 1, 32'h8888_8888);
      settle();
      chk("rm4_rv0", m0_rvalid, 0);
      chk("rm4_rv1", m1_rvalid, 0);
      nxt();
      slv(0, 0, 0);
      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      failures++;
      $display("FAIL timeout obs=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
